// File: rtl/apple_bus_regfile.sv
// Apple II slot-bus register file: config regs, command FIFO, status, pointer-driven fetch port.
// Optional PHI0 watchdog built when APPLE_BUS_WDOG_EN is defined.
module apple_bus_regfile #(
  parameter int ADDR_W      = 4,
  parameter int NUM_CFG     = 8,
  parameter int SYNC_STAGES = 3,
  parameter int CMD_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 phi0,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 data_oe,
  input  logic                 ndevice_select,
  input  logic                 r_nw,
  output logic [8*NUM_CFG-1:0] cfg_out,
  input  logic [3:0]           status_in,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_data,
  input  logic                 cmd_ready,
  output logic                 mem_req,
  output logic [7:0]           mem_addr,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 bus_lost
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(NUM_CFG);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_CFG + 1);
  localparam logic [ADDR_W-1:0] A_PTR  = ADDR_W'(NUM_CFG + 2);
  localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(NUM_CFG + 3);
  localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(NUM_CFG + 4);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} fstate_t;

  // Equal-depth synchronizers keep phi0, select and payload aligned to the same stage.
  logic [SYNC_STAGES-1:0] phi0_sr, nsel_sr, rnw_sr;
  logic [ADDR_W-1:0]      addr_sr [SYNC_STAGES];
  logic [7:0]             din_sr  [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi0_sr <= '0;
      nsel_sr <= '1;
      rnw_sr  <= '1;
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        addr_sr[k] <= '0;
        din_sr[k]  <= '0;
      end
    end else begin
      phi0_sr    <= {phi0_sr[SYNC_STAGES-2:0], phi0};
      nsel_sr    <= {nsel_sr[SYNC_STAGES-2:0], ndevice_select};
      rnw_sr     <= {rnw_sr[SYNC_STAGES-2:0], r_nw};
      addr_sr[0] <= addr;
      din_sr[0]  <= data_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        addr_sr[k] <= addr_sr[k-1];
        din_sr[k]  <= din_sr[k-1];
      end
    end
  end

  logic phi0_s, nsel_s, phi0_q, phi0_fall;
  assign phi0_s    = phi0_sr[SYNC_STAGES-1];
  assign nsel_s    = nsel_sr[SYNC_STAGES-1];
  assign phi0_fall = phi0_q && !phi0_s;

  logic              lat_valid, lat_rnw;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi0_q    <= 1'b0;
      lat_valid <= 1'b0;
      lat_rnw   <= 1'b1;
      lat_addr  <= '0;
      lat_data  <= '0;
    end else begin
      phi0_q    <= phi0_s;
      lat_valid <= phi0_fall && !nsel_s;
      if (phi0_fall && !nsel_s) begin
        lat_rnw  <= rnw_sr[SYNC_STAGES-1];
        lat_addr <= addr_sr[SYNC_STAGES-1];
        lat_data <= din_sr[SYNC_STAGES-1];
      end
    end
  end

`ifdef APPLE_BUS_WDOG_EN
  logic [15:0] wdog_cnt;
  logic        bus_lost_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt   <= '0;
      bus_lost_q <= 1'b0;
    end else if (phi0_q != phi0_s) begin
      wdog_cnt   <= '0;
      bus_lost_q <= 1'b0;
    end else if (wdog_cnt == 16'hFFFF) begin
      bus_lost_q <= 1'b1;
    end else begin
      wdog_cnt <= wdog_cnt + 16'd1;
    end
  end
  assign bus_lost = bus_lost_q;
`else
  assign bus_lost = 1'b0;
`endif

  logic wr_stb, rd_stb;
  assign wr_stb = lat_valid && !bus_lost && !lat_rnw;
  assign rd_stb = lat_valid && !bus_lost && lat_rnw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_oe <= 1'b0;
    else        data_oe <= !ndevice_select && r_nw && !bus_lost;
  end

  logic [7:0] cfg_q [NUM_CFG];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CFG; k++)
        if (wr_stb && lat_addr == ADDR_W'(k)) cfg_q[k] <= lat_data;
    end
  end

  always_comb begin
    cfg_out = '0;
    for (int unsigned k = 0; k < NUM_CFG; k++) cfg_out[8*k +: 8] = cfg_q[k];
  end

  logic [7:0]    fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          overflow, push, pop, full, push_ok;

  assign full      = (cnt == CW'(CMD_DEPTH));
  assign cmd_valid = (cnt != '0);
  assign cmd_data  = fifo_mem[rp];
  assign push      = wr_stb && lat_addr == A_CMD;
  assign pop       = cmd_valid && cmd_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a paired push.
  assign push_ok   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wp] <= lat_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      if (push_ok && !pop)      cnt <= cnt + 1'b1;
      else if (!push_ok && pop) cnt <= cnt - 1'b1;
      if (push && full && !pop)               overflow <= 1'b1;
      else if (rd_stb && lat_addr == A_STAT) overflow <= 1'b0;
    end
  end

  fstate_t    state, state_d;
  logic       refetch, refetch_d, load, trigger, ptr_wr, data_rd, fetch_pending;
  logic [7:0] ptr, data_reg;

  assign ptr_wr  = wr_stb && lat_addr == A_PTR;
  assign data_rd = rd_stb && lat_addr == A_DATA;
  assign trigger = ptr_wr || data_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      refetch  <= 1'b0;
      ptr      <= '0;
      data_reg <= '0;
    end else begin
      state   <= state_d;
      refetch <= refetch_d;
      if (ptr_wr)       ptr <= lat_data;
      else if (data_rd) ptr <= ptr + 8'd1;
      if (load) data_reg <= mem_rdata;
    end
  end

  always_comb begin
    state_d   = state;
    refetch_d = refetch;
    load      = 1'b0;
    case (state)
      S_IDLE: if (trigger) state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
        if (trigger) refetch_d = 1'b1;
      end
      S_WAIT: begin
        if (trigger) refetch_d = 1'b1;
        if (mem_ack) begin
          load      = 1'b1;
          refetch_d = 1'b0;
          state_d   = (refetch || trigger) ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req       = (state != S_IDLE);
  assign mem_addr      = ptr;
  assign fetch_pending = (state != S_IDLE) || refetch;

  always_comb begin
    data_out = '0;
    for (int unsigned k = 0; k < NUM_CFG; k++)
      if (addr == ADDR_W'(k)) data_out = cfg_q[k];
    if (addr == A_CMD)       data_out = 8'(cnt);
    else if (addr == A_STAT) data_out = {overflow, full, !cmd_valid, fetch_pending, status_in};
    else if (addr == A_PTR)  data_out = ptr;
    else if (addr == A_DATA) data_out = data_reg;
    else if (addr == A_ID)   data_out = 8'hA5;
  end

endmodule
